aes_mm_ctrl_regfile: RTL and testbench
======================================

// Module: aes_mm_ctrl_regfile
// PURPOSE
//  Parametrised successor of the single-channel AES register controller: Avalon-MM slave register file serving
//  CHANNELS independent message channels. Each channel has a start/busy/done state machine, a programmable word count
//  and sampled adder/remover word counters. Sits between the host Avalon-MM master and the per-channel AES word adder/remover.
// PARAMETERS
//  CHANNELS      2                  number of message channels (1..8)
//  READ_LATENCY  1                  cycles from accepted read to readdatavalid (1..4)
//  ADDR_W        ADDRESS_SIZE       Avalon address width (word addressed); must hold CHANNELS*4+2
//  DATA_W        REG_SIZE           Avalon data width (>= CNT_W+8)
//  CNT_W         WORD_COUNTER_SIZE  message word counter width
// PORTS
//  clk                      in   1                 system clock
//  rst_n                    in   1                 asynchronous active-low reset
//  mm_master_address        in   ADDR_W            register word address
//  mm_master_write          in   1                 write strobe
//  mm_master_writedata      in   DATA_W            write data
//  mm_master_read           in   1                 read strobe
//  mm_master_readdatavalid  out  1                 read data valid
//  mm_master_readdata       out  DATA_W            read data
//  mm_master_waitrequest    out  1                 slave stall
//  msg_start                out  CHANNELS          per-channel one-cycle start pulse
//  msg_words_out            out  CHANNELS*CNT_W    per-channel programmed word count (ch0 in LSBs)
//  msg_words_in_adder       in   CHANNELS*CNT_W    per-channel words seen by adder
//  msg_words_in_remover     in   CHANNELS*CNT_W    per-channel words emitted by remover
// BEHAVIOUR
//  Reset: all outputs 0 except waitrequest=1; all registers 0; all channels IDLE.
//  waitrequest: registered; 1 during reset and the first clk after rst_n rises, then 0 permanently. Txn accepted when strobe & !waitrequest.
//  Map (word addr, ch base = ch*4):
//   +0 CTRL  W: b0 start, b1 clr_done, b2 clr_err. R: b0 busy, b1 done, b2 err, b[5:3] state
//   +1 WORDS_OUT  RW [CNT_W-1:0], drives msg_words_out; write ignored (err set) while channel BUSY
//   +2 ADDER_CNT  RO msg_words_in_adder zero-extended; +3 REMOVER_CNT RO likewise
//   CHANNELS*4+0 ID RO = {8'hAE, 8'(CHANNELS), 8'(READ_LATENCY), 8'h02} (low DATA_W bits)
//   CHANNELS*4+1 STATUS RO: [CHANNELS-1:0] busy, [CHANNELS+7:8] done
//   Other addresses: reads return 0, writes dropped, readdatavalid still issued.
//  Channel FSM (per ch): IDLE -start & WORDS_OUT!=0-> START (msg_start=1 one cycle) -> BUSY;
//   BUSY -remover_cnt >= WORDS_OUT-> DONE (done=1 sticky); DONE -start-> START; DONE -clr_done-> IDLE.
//   start with WORDS_OUT==0: no pulse, err=1, state unchanged. start while START/BUSY: ignored, err=1.
//   start and clr_done in same write from DONE: start wins, done cleared. err sticky until clr_err.
//  Reads: data snapshot taken at acceptance cycle; readdatavalid high exactly READ_LATENCY cycles later, one cycle wide;
//   back-to-back reads each cycle fully pipelined, order preserved.
//  Write and read both asserted same cycle: write performed, read dropped (no readdatavalid).
//  Write to WORDS_OUT and completion same cycle: FSM uses pre-write value.
//  Counter compare unsigned, CNT_W bits; no wrap handling (remover never exceeds programmed count).
//  Reset mid-operation: pipeline flushed, pending readdatavalid lost, FSMs to IDLE immediately.
// STRUCTURE
//  aes_pack: ch_state_t enum {IDLE,START,BUSY,DONE}; REG_CTRL/REG_WORDS_OUT/REG_ADDER/REG_REMOVER offsets;
//   CTRL bit indices; ID_MAGIC=8'hAE; existing ADDRESS_SIZE/REG_SIZE/WORD_COUNTER_SIZE.
//  Sub-module aes_msg_channel (one FSM + WORDS_OUT + sticky bits), instantiated CHANNELS times via generate;
//   top holds address decode, readdata mux and READ_LATENCY shift pipeline.
// TESTING
//  1 Reset release: waitrequest 1 until 1 clk after rst_n rise; read ID (CHANNELS=2,LAT=1) -> 0xAE020102 one cycle later.
//  2 Write ch1 WORDS_OUT=5, CTRL=1 -> msg_start[1] one-cycle pulse; drive remover[1]=5 -> STATUS done bit 9 set, busy bit 1 clear.
//  3 Start ch0 with WORDS_OUT=0 -> no pulse, CTRL.err=1; write CTRL=4 -> err=0.
//  4 READ_LATENCY=3, reads on 4 consecutive cycles to addr 0..3 -> 4 valids on cycles +3..+6 with matching snapshot data.
//  5 Start ch0 while BUSY -> no second pulse, err=1; WORDS_OUT write ignored, readback unchanged.
//  6 Assert rst_n low mid-BUSY with read pending -> no readdatavalid, all FSMs IDLE, msg_words_out=0.

Source files
------------

// File: rtl/aes_mm_ctrl_regfile_pkg.sv
//----------------------------------------------------------------------------
// aes_pack : shared types and constants for the AES message register file
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package aes_pack;

  localparam int ADDRESS_SIZE      = 8;
  localparam int REG_SIZE          = 32;
  localparam int WORD_COUNTER_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } ch_state_t;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_WORDS_OUT = 2'd1;
  localparam logic [1:0] REG_ADDER     = 2'd2;
  localparam logic [1:0] REG_REMOVER   = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_CLR_ERR  = 2;

  localparam logic [7:0] ID_MAGIC = 8'hAE;

  function automatic logic is_busy(input ch_state_t s);
    return (s == START) || (s == BUSY);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_mm_ctrl_regfile_channel.sv
//----------------------------------------------------------------------------
// aes_msg_channel : one message channel - start/busy/done FSM, word count, err
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module aes_msg_channel
  import aes_pack::*;
#(
  parameter int CNT_W = WORD_COUNTER_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ctrl_we,
  input  logic [2:0]       i_ctrl_wdata,
  input  logic             i_words_we,
  input  logic [CNT_W-1:0] i_words_wdata,
  input  logic [CNT_W-1:0] i_remover_cnt,
  output logic             o_start,
  output logic [CNT_W-1:0] o_words,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output ch_state_t        o_state
);

  ch_state_t        state_d, state_q;
  logic [CNT_W-1:0] words_d, words_q;
  logic             err_d, err_q;
  logic             w_start, w_clr_done, w_clr_err;

  always_comb begin
    state_d    = state_q;
    words_d    = words_q;
    err_d      = err_q;
    w_start    = i_ctrl_we & i_ctrl_wdata[CTRL_START];
    w_clr_done = i_ctrl_we & i_ctrl_wdata[CTRL_CLR_DONE];
    w_clr_err  = i_ctrl_we & i_ctrl_wdata[CTRL_CLR_ERR];

    // Clear first so a same-write error condition still leaves err set.
    if (w_clr_err) err_d = 1'b0;

    if (i_words_we) begin
      if (is_busy(state_q)) err_d = 1'b1;
      else                  words_d = i_words_wdata;
    end

    case (state_q)
      IDLE, DONE: begin
        if (w_start && (words_q != '0)) begin
          state_d = START;
        end else begin
          if (w_start) err_d = 1'b1;
          if (w_clr_done && (state_q == DONE)) state_d = IDLE;
        end
      end
      START: begin
        if (w_start) err_d = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (w_start) err_d = 1'b1;
        if (i_remover_cnt >= words_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign o_start = (state_q == START);
  assign o_words = words_q;
  assign o_busy  = is_busy(state_q);
  assign o_done  = (state_q == DONE);
  assign o_err   = err_q;
  assign o_state = state_q;

endmodule

`default_nettype wire

// File: rtl/aes_mm_ctrl_regfile.sv
//----------------------------------------------------------------------------
// aes_mm_ctrl_regfile : Avalon-MM register file for CHANNELS AES message channels
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module aes_mm_ctrl_regfile
  import aes_pack::*;
#(
  parameter int CHANNELS     = 2,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = ADDRESS_SIZE,
  parameter int DATA_W       = REG_SIZE,
  parameter int CNT_W        = WORD_COUNTER_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         mm_master_address,
  input  logic                      mm_master_write,
  input  logic [DATA_W-1:0]         mm_master_writedata,
  input  logic                      mm_master_read,
  output logic                      mm_master_readdatavalid,
  output logic [DATA_W-1:0]         mm_master_readdata,
  output logic                      mm_master_waitrequest,
  output logic [CHANNELS-1:0]       msg_start,
  output logic [CHANNELS*CNT_W-1:0] msg_words_out,
  input  logic [CHANNELS*CNT_W-1:0] msg_words_in_adder,
  input  logic [CHANNELS*CNT_W-1:0] msg_words_in_remover
);

  localparam int                c_ahi_w       = ADDR_W - 2;
  localparam logic [31:0]       c_id          = {ID_MAGIC, 8'(CHANNELS), 8'(READ_LATENCY), 8'h02};
  localparam logic [ADDR_W-1:0] c_id_addr     = ADDR_W'(CHANNELS * 4);
  localparam logic [ADDR_W-1:0] c_status_addr = ADDR_W'(CHANNELS * 4 + 1);

  logic                    wait_d, wait_q;
  logic                    w_wr_acc, w_rd_acc;
  logic [DATA_W-1:0]       w_rdata;
  logic [CHANNELS+7:0]     w_status;
  logic [CHANNELS-1:0]     w_ctrl_we, w_words_we;
  logic [CHANNELS-1:0]     w_busy, w_done, w_err;
  logic [CNT_W-1:0]        w_words [CHANNELS];
  ch_state_t               w_state [CHANNELS];
  logic [READ_LATENCY-1:0] rvalid_d, rvalid_q;
  logic [DATA_W-1:0]       rdata_d [READ_LATENCY];
  logic [DATA_W-1:0]       rdata_q [READ_LATENCY];
  logic                    w_unused_wdata;

  assign w_unused_wdata = ^mm_master_writedata[DATA_W-1:CNT_W];

  // Write beats read when both strobes arrive together.
  assign w_wr_acc = mm_master_write & ~wait_q;
  assign w_rd_acc = mm_master_read & ~mm_master_write & ~wait_q;
  assign wait_d   = 1'b0;

  always_comb begin
    w_rdata    = '0;
    w_ctrl_we  = '0;
    w_words_we = '0;
    w_status   = '0;
    w_status[CHANNELS-1:0]  = w_busy;
    w_status[CHANNELS+7:8]  = w_done;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mm_master_address[ADDR_W-1:2] == c_ahi_w'(c)) begin
        w_ctrl_we[c]  = w_wr_acc & (mm_master_address[1:0] == REG_CTRL);
        w_words_we[c] = w_wr_acc & (mm_master_address[1:0] == REG_WORDS_OUT);
        case (mm_master_address[1:0])
          REG_CTRL:      w_rdata = DATA_W'({1'b0, w_state[c], w_err[c], w_done[c], w_busy[c]});
          REG_WORDS_OUT: w_rdata = DATA_W'(w_words[c]);
          REG_ADDER:     w_rdata = DATA_W'(msg_words_in_adder[c*CNT_W +: CNT_W]);
          REG_REMOVER:   w_rdata = DATA_W'(msg_words_in_remover[c*CNT_W +: CNT_W]);
          default:       w_rdata = '0;
        endcase
      end
    end
    if (mm_master_address == c_id_addr)     w_rdata = DATA_W'(c_id);
    if (mm_master_address == c_status_addr) w_rdata = DATA_W'(w_status);
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      aes_msg_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ctrl_we     (w_ctrl_we[g]),
        .i_ctrl_wdata  (mm_master_writedata[2:0]),
        .i_words_we    (w_words_we[g]),
        .i_words_wdata (mm_master_writedata[CNT_W-1:0]),
        .i_remover_cnt (msg_words_in_remover[g*CNT_W +: CNT_W]),
        .o_start       (msg_start[g]),
        .o_words       (w_words[g]),
        .o_busy        (w_busy[g]),
        .o_done        (w_done[g]),
        .o_err         (w_err[g]),
        .o_state       (w_state[g])
      );
      assign msg_words_out[g*CNT_W +: CNT_W] = w_words[g];
    end
  endgenerate

  // Read data is captured at acceptance and then only shifted.
  always_comb begin
    rvalid_d    = '0;
    rvalid_d[0] = w_rd_acc;
    rdata_d[0]  = w_rdata;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rvalid_d[i] = rvalid_q[i-1];
      rdata_d[i]  = rdata_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q   <= 1'b1;
      rvalid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rdata_q[i] <= '0;
    end else begin
      wait_q   <= wait_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < READ_LATENCY; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  assign mm_master_waitrequest   = wait_q;
  assign mm_master_readdatavalid = rvalid_q[READ_LATENCY-1];
  assign mm_master_readdata      = rdata_q[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_aes_mm_ctrl_regfile.sv
//----------------------------------------------------------------------------
// tb_aes_mm_ctrl_regfile : directed bench, two DUTs (read latency 1 and 3)
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_aes_mm_ctrl_regfile;

  localparam int CH = 2;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  address = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] adder = 32'h0007_0011;
  logic [31:0] remover = '0;

  logic        rdv1, wq1, rdv3, wq3;
  logic [31:0] rd1, rd3, wout1, wout3;
  logic [1:0]  st1, st3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  aes_mm_ctrl_regfile #(.CHANNELS(CH), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mm_master_address(address), .mm_master_write(write),
    .mm_master_writedata(writedata), .mm_master_read(read), .mm_master_readdatavalid(rdv1),
    .mm_master_readdata(rd1), .mm_master_waitrequest(wq1), .msg_start(st1),
    .msg_words_out(wout1), .msg_words_in_adder(adder), .msg_words_in_remover(remover));

  aes_mm_ctrl_regfile #(.CHANNELS(CH), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mm_master_address(address), .mm_master_write(write),
    .mm_master_writedata(writedata), .mm_master_read(read), .mm_master_readdatavalid(rdv3),
    .mm_master_readdata(rd3), .mm_master_waitrequest(wq3), .msg_start(st3),
    .msg_words_out(wout3), .msg_words_in_adder(adder), .msg_words_in_remover(remover));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 start pulse, 2 running, 3 finished.
  int          m_phase [CH];
  logic [15:0] m_words [CH];
  bit          m_err   [CH];
  bit          m_wait = 1'b1;
  int          q_due1[$], q_due3[$];
  logic [31:0] q_dat1[$], q_dat3[$];

  function automatic bit m_busy(input int c);
    return (m_phase[c] == 1) || (m_phase[c] == 2);
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] a, input int lat);
    logic [31:0] v;
    int c;
    v = 0;
    if (int'(a) < CH * 4) begin
      c = int'(a) / 4;
      case (int'(a) % 4)
        0: v = (m_busy(c) ? 1 : 0) + (m_phase[c] == 3 ? 2 : 0) + (m_err[c] ? 4 : 0) + m_phase[c] * 8;
        1: v = 32'(m_words[c]);
        2: v = (adder >> (16 * c)) & 32'hFFFF;
        default: v = (remover >> (16 * c)) & 32'hFFFF;
      endcase
    end else if (int'(a) == CH * 4) begin
      v = 32'hAE00_0002 + 32'(CH * 65536) + 32'(lat * 256);
    end else if (int'(a) == CH * 4 + 1) begin
      for (int k = 0; k < CH; k++) begin
        if (m_busy(k))      v = v + 32'(1 << k);
        if (m_phase[k] == 3) v = v + 32'(1 << (8 + k));
      end
    end
    return v;
  endfunction

  always @(posedge clk) begin
    bit wacc, racc;
    logic [1:0]  es;
    logic [31:0] ew;
    bit ev;
    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_phase[c] = 0; m_words[c] = '0; m_err[c] = 1'b0;
      end
      m_wait = 1'b1;
      q_due1.delete(); q_dat1.delete(); q_due3.delete(); q_dat3.delete();
    end else begin
      wacc = write && !m_wait;
      racc = read && !write && !m_wait;
      if (racc) begin
        q_due1.push_back(cyc);     q_dat1.push_back(mread(address, 1));
        q_due3.push_back(cyc + 2); q_dat3.push_back(mread(address, 3));
      end
      for (int c = 0; c < CH; c++) begin
        bit s, cd, ce, ww;
        s  = wacc && (address == 8'(c * 4)) && writedata[0];
        cd = wacc && (address == 8'(c * 4)) && writedata[1];
        ce = wacc && (address == 8'(c * 4)) && writedata[2];
        ww = wacc && (address == 8'(c * 4 + 1));
        if (ce) m_err[c] = 1'b0;
        if (ww) begin
          if (m_busy(c)) m_err[c] = 1'b1;
          else           m_words[c] = writedata[15:0];
        end
        if (m_phase[c] == 1) begin
          if (s) m_err[c] = 1'b1;
          m_phase[c] = 2;
        end else if (m_phase[c] == 2) begin
          if (s) m_err[c] = 1'b1;
          if (remover[16*c +: 16] >= m_words[c]) m_phase[c] = 3;
        end else if (s && m_words[c] != 0) begin
          m_phase[c] = 1;
        end else begin
          if (s) m_err[c] = 1'b1;
          if (cd && m_phase[c] == 3) m_phase[c] = 0;
        end
      end
      m_wait = 1'b0;
    end

    #1;
    es = '0;
    ew = '0;
    for (int c = 0; c < CH; c++) begin
      es[c] = (m_phase[c] == 1);
      ew[16*c +: 16] = m_words[c];
    end
    chk("waitreq_l1", wq1, m_wait);
    chk("waitreq_l3", wq3, m_wait);
    chk("msg_start_l1", st1, es);
    chk("msg_start_l3", st3, es);
    chk("words_out_l1", wout1, ew);
    chk("words_out_l3", wout3, ew);
    ev = (q_due1.size() != 0) && (q_due1[0] == cyc);
    chk("rvalid_l1", rdv1, ev);
    if (ev) begin
      chk("rdata_l1", rd1, q_dat1[0]);
      void'(q_due1.pop_front()); void'(q_dat1.pop_front());
    end
    ev = (q_due3.size() != 0) && (q_due3[0] == cyc);
    chk("rvalid_l3", rdv3, ev);
    if (ev) begin
      chk("rdata_l3", rd3, q_dat3[0]);
      void'(q_due3.pop_front()); void'(q_dat3.pop_front());
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d = '0;
    @(negedge clk);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (rdv1) begin
        d = rd1; got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("rd_timeout", 0, 1);
  endtask

  logic        v3 [8];
  logic [31:0] d3 [8];
  logic [31:0] rdat;

  initial begin
    // Reset release and ID
    repeat (3) @(negedge clk);
    chk("waitreq_in_reset", wq1, 1'b1);
    rst_n = 1'b1;
    chk("waitreq_at_release", wq1, 1'b1);
    rd(8'd8, rdat);
    chk("id_l1", rdat, 32'hAE02_0102);

    // Channel 1 full run
    wr(8'd5, 32'd5);
    wr(8'd4, 32'd1);
    chk("ch1_start_pulse", st1, 2'b10);
    @(negedge clk);
    chk("ch1_start_pulse_end", st1, 2'b00);
    remover[31:16] = 16'd5;
    repeat (2) @(negedge clk);
    rd(8'd9, rdat);
    chk("status_ch1_done", rdat, 32'h0000_0200);
    rd(8'd4, rdat);
    chk("ctrl_ch1_done", rdat, 32'h0000_001A);

    // Start with zero word count
    wr(8'd0, 32'd1);
    chk("zero_words_no_pulse", st1, 2'b00);
    rd(8'd0, rdat);
    chk("ctrl_ch0_err", rdat, 32'h0000_0004);
    wr(8'd0, 32'd4);
    rd(8'd0, rdat);
    chk("ctrl_ch0_err_clr", rdat, 32'h0000_0000);

    // Restart and write while busy
    wr(8'd1, 32'd3);
    wr(8'd0, 32'd1);
    chk("ch0_start_pulse", st1, 2'b01);
    wr(8'd0, 32'd1);
    chk("ch0_restart_no_pulse", st1, 2'b00);
    rd(8'd0, rdat);
    chk("ctrl_ch0_busy_err", rdat, 32'h0000_0015);
    wr(8'd1, 32'd9);
    rd(8'd1, rdat);
    chk("words_ch0_unchanged", rdat, 32'h0000_0003);

    // Pipelined reads at latency 3
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v3[i] = rdv3;
      d3[i] = rd3;
      read = (i < 4);
      address = 8'(i);
    end
    read = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("l3_valid_slot%0d", i), v3[i], (i >= 3 && i <= 6));
    chk("l3_data_ctrl", d3[3], 32'h0000_0015);
    chk("l3_data_words", d3[4], 32'h0000_0003);
    chk("l3_data_adder", d3[5], 32'h0000_0011);
    chk("l3_data_remover", d3[6], 32'h0000_0000);

    // Reset mid-operation with a read in flight
    repeat (4) @(negedge clk);
    address = 8'd1; read = 1'b1;
    @(negedge clk);
    read = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rvalid_l3", rdv3, 1'b0);
      chk("rst_words_out", wout1, 32'h0);
      chk("rst_waitreq", wq1, 1'b1);
    end
    rst_n = 1'b1;
    rd(8'd0, rdat);
    chk("ctrl_ch0_after_rst", rdat, 32'h0);
    rd(8'd4, rdat);
    chk("ctrl_ch1_after_rst", rdat, 32'h0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
